// File: rtl/tristate_bus_reader_if.sv
// Handshake and bus signals between the tri-state register bank, the scan
// reader and the downstream consumer of captured words.
interface tristate_bus_reader_if #(
    parameter int unsigned NrOfBits = 8,
    parameter int unsigned NrOfRegs = 4,
    parameter int unsigned IdxBits  = 2
);
    logic                Start;
    logic [NrOfRegs-1:0] RegMask;
    logic [NrOfBits-1:0] BusIn;
    logic [NrOfRegs-1:0] Cs;
    logic [NrOfBits-1:0] DataOut;
    logic [IdxBits-1:0]  DataIdx;
    logic                DataValid;
    logic                DataReady;
    logic                Busy;
    logic                Done;

    // Reader side: owns the chip selects and the captured-word handshake.
    modport master (
        input  Start, RegMask, BusIn, DataReady,
        output Cs, DataOut, DataIdx, DataValid, Busy, Done
    );

    // Environment side: register bank plus scan requester and word consumer.
    modport slave (
        output Start, RegMask, BusIn, DataReady,
        input  Cs, DataOut, DataIdx, DataValid, Busy, Done
    );
endinterface

// File: rtl/tristate_bus_reader.sv
// Scans a mask of chip-selected registers on a shared tri-state bus in
// ascending index order. Each register is selected alone, given a settle
// window, captured, and handed downstream on a valid/ready handshake.
module tristate_bus_reader #(
    parameter int unsigned NrOfBits     = 8,
    parameter int unsigned NrOfRegs     = 4,
    parameter int unsigned IdxBits      = 2,
    parameter int unsigned SettleCycles = 1
) (
    input logic                   Clock,
    input logic                   Reset,
    input logic                   Tick,
    tristate_bus_reader_if.master bus
);
    localparam int unsigned CntBits = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [CntBits-1:0] CntLast = CntBits'(SettleCycles - 1);

    typedef enum logic [1:0] {StIdle, StSelect, StPresent, StDone} state_e;

    state_e              state_q;
    logic [NrOfRegs-1:0] mask_q;
    logic [IdxBits-1:0]  idx_q;
    logic [CntBits-1:0]  cnt_q;
    logic [NrOfRegs-1:0] cs_q;
    logic [NrOfBits-1:0] data_q;
    logic [IdxBits-1:0]  data_idx_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic [NrOfRegs-1:0] mask_rest;

    // Index of the lowest set bit; callers guarantee the mask is nonzero.
    function automatic logic [IdxBits-1:0] lowest_idx(input logic [NrOfRegs-1:0] m);
        logic [IdxBits-1:0] r;
        r = '0;
        for (int i = NrOfRegs - 1; i >= 0; i--) begin
            if (m[i]) r = IdxBits'(i);
        end
        return r;
    endfunction

    // Chip-select pattern driving exactly one register onto the bus.
    function automatic logic [NrOfRegs-1:0] select_cs(input logic [IdxBits-1:0] idx);
        return ~(NrOfRegs'(1) << idx);
    endfunction

    // Mask left over once the word currently presented is accepted.
    assign mask_rest = mask_q & ~(NrOfRegs'(1) << idx_q);

    // Scan FSM with all outputs registered; Tick gates every state change.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            cs_q       <= '1;
            data_q     <= '0;
            data_idx_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (Tick) begin
            case (state_q)
                StIdle: begin
                    if (bus.Start) begin
                        busy_q <= 1'b1;
                        if (bus.RegMask != '0) begin
                            mask_q  <= bus.RegMask;
                            idx_q   <= lowest_idx(bus.RegMask);
                            cs_q    <= select_cs(lowest_idx(bus.RegMask));
                            cnt_q   <= '0;
                            state_q <= StSelect;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StSelect: begin
                    if (cnt_q == CntLast) begin
                        data_q     <= bus.BusIn;
                        data_idx_q <= idx_q;
                        valid_q    <= 1'b1;
                        cs_q       <= '1;
                        state_q    <= StPresent;
                    end else begin
                        cnt_q <= cnt_q + CntBits'(1);
                    end
                end
                StPresent: begin
                    if (bus.DataReady) begin
                        valid_q <= 1'b0;
                        mask_q  <= mask_rest;
                        if (mask_rest != '0) begin
                            // Next register goes straight onto the bus: no idle gap.
                            idx_q   <= lowest_idx(mask_rest);
                            cs_q    <= select_cs(lowest_idx(mask_rest));
                            cnt_q   <= '0;
                            state_q <= StSelect;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.Cs        = cs_q;
    assign bus.DataOut   = data_q;
    assign bus.DataIdx   = data_idx_q;
    assign bus.DataValid = valid_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
endmodule

// File: doc/tristate_bus_reader.md
Name: tristate_bus_reader

Overview:
- Bus-side reader for banks of chip-selected registers that drive a shared tri-state bus.
- Each register releases the bus when its cs is 1 and drives Q when its cs is 0.
- On Start, the block walks a mask of register indices in ascending order, asserting one cs low at a time. It waits a settle window, captures the bus and presents each word downstream on a valid/ready handshake.
- Sits between the register bank and the recognition datapath or debug readout.

Parameters:
- NrOfBits, 8, bus/data width.
- NrOfRegs, 4, number of registers on the bus (2..16).
- IdxBits, 2, width of register index; must satisfy 2^IdxBits >= NrOfRegs.
- SettleCycles, 1, enabled ticks cs is held low before capture (>=1).

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Tick  in  1  clock enable; state advances only on edges where Tick=1.
- Start  in  1  begin a scan; sampled only in IDLE.
- RegMask  in  NrOfRegs  bit i=1 means read register i; latched at Start.
- BusIn  in  NrOfBits  shared tri-state bus (register Q outputs).
- Cs  out  NrOfRegs  per-register chip select; 1=release bus, 0=drive bus.
- DataOut  out  NrOfBits  captured word.
- DataIdx  out  IdxBits  register index of DataOut.
- DataValid  out  1  DataOut/DataIdx valid.
- DataReady  in  1  downstream accepts word.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-tick pulse at end of scan.

Behaviour:
- Reset (synchronous, priority over everything, regardless of Tick):
  - Cs = all ones; DataOut=0, DataIdx=0, DataValid=0, Busy=0, Done=0.
  - Latched mask=0; settle counter=0; state=IDLE.
  - Reset asserted mid-scan releases the bus on the very next edge and drops any pending word.
- Tick=0: all registers hold, including DataValid and Cs. No handshake completes.
- States: IDLE, SELECT, PRESENT, DONE.
- IDLE:
  - On Tick & Start with RegMask!=0: latch RegMask and set idx = lowest set bit.
  - In that same edge, drive Cs[idx]=0, clear the counter and go to SELECT.
  - On Tick & Start with RegMask==0: go directly to DONE; no Cs activity and no DataValid.
- SELECT (Cs[idx]=0, all other Cs bits 1):
  - Each Tick: if counter==SettleCycles-1, capture BusIn into DataOut and set DataIdx=idx.
  - In that capture edge: DataValid=1, Cs=all ones, state=PRESENT.
  - Otherwise: counter+1.
  - Cs is low for exactly SettleCycles enabled ticks.
- PRESENT (Cs all ones):
  - DataOut/DataIdx are stable while DataValid=1.
  - On Tick & DataReady: DataValid=0 and clear latched mask bit idx.
  - In that edge, if the remaining mask is nonzero: idx = next lowest set bit, Cs[idx]=0, counter=0, state=SELECT.
  - If the remaining mask is zero: state=DONE.
  - There are no bus-idle ticks between words beyond the handshake.
- DONE: Done=1 for exactly one enabled tick (held through Tick=0 gaps), then IDLE.
- Start while Busy is ignored. RegMask changes after Start have no effect on the current scan.
- Mask bits at indices >= NrOfRegs do not exist. Scan order is strictly ascending and each selected register is read exactly once.
- Bus-safety invariant: at most one Cs bit is 0 on any cycle. Cs is never 0 in IDLE, PRESENT or DONE.
- BusIn is captured verbatim with no filtering; unselected-register contention is the bank's responsibility.
- Busy=1 from the edge leaving IDLE until the edge returning to IDLE.

Test Plan:
- Reset, Tick=1, Start with RegMask=4'b1010, registers 1=8'h3C and 3=8'hA5, DataReady=1 -> Cs=1101 one tick, then word (idx1, 3C); Cs=0111 one tick, then word (idx3, A5); Done pulse; Cs=1111 in all other cycles.
- SettleCycles=3, RegMask=0001, reg0=8'h7E -> Cs[0]=0 for exactly 3 ticks; DataOut=7E and DataIdx=0 on the capture edge.
- Backpressure: RegMask=0011, DataReady=0 for 5 ticks after first DataValid -> DataOut/DataValid hold and Cs stays 1111; register 1 is not selected until the handshake.
- Tick toggling 1,0,1,0 during a scan -> Cs, counter and DataValid change only on Tick=1 edges; Done stays high across the Tick=0 gap; overall sequence is identical to the Tick=1 run.
- RegMask=0 with Start -> Done pulse next edge, DataValid never 1, Cs always 1111. Start asserted while Busy -> ignored.
- Reset asserted while in SELECT with Cs=1011 -> next edge Cs=1111, DataValid=0, Busy=0, state IDLE; a new Start works normally.
